tug_input_conditioner: RTL and testbench
========================================

# tug_input_conditioner

Upstream input stage for the tug-of-war playfield. Takes the two raw, asynchronous player keys and produces clean single-cycle press pulses on `leftButton` and `rightButton`, which drive every playfield light cell and the centre cell. Each key is synchronised, debounced, and edge-detected. Holding a key yields exactly one pulse. Simultaneous presses cancel, so a tie moves nothing.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive sampled cycles a new key level must hold before it is accepted. Must be ≥ 1.
- `ACTIVE_LOW`, default 1: 1 means a raw key reads 0 when pressed (board KEYs); 0 means a raw key reads 1 when pressed.
- `clk` input 1: system clock. All state updates on the rising edge.
- `Reset` input 1: reset Reset, synchronous, active-high; clock clk.
- `keyL_raw` input 1: left player key, asynchronous, may bounce.
- `keyR_raw` input 1: right player key, asynchronous, may bounce.
- `leftButton` output 1: registered one-cycle pulse for an accepted left press after tie filtering.
- `rightButton` output 1: registered one-cycle pulse for an accepted right press after tie filtering.
- `leftHeld` output 1: debounced left key level, 1 = pressed.
- `rightHeld` output 1: debounced right key level, 1 = pressed.

## Operation
- Two identical channels (L, R) feed a shared tie filter.
- **Synchroniser:** two-flop chain per key, then polarity normalised so that 1 = pressed. On Reset both flops load the released raw level (1 if `ACTIVE_LOW`, else 0).
- **Debounce FSM per channel.** States: RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND. A counter `cnt` has width clog2(`DEBOUNCE_CYCLES`+1).
  - RELEASED: if the synced value is 1, go to PRESS_PEND with cnt=1. If `DEBOUNCE_CYCLES`=1, go directly to PRESSED.
  - PRESS_PEND: if synced is 0, return to RELEASED with cnt=0. Else cnt+1; when cnt reaches `DEBOUNCE_CYCLES`, go to PRESSED with cnt=0 and raise the raw press event.
  - PRESSED: if synced is 0, go to RELEASE_PEND with cnt=1. The same `DEBOUNCE_CYCLES` rule applies in the release direction.
  - RELEASE_PEND: if synced is 1, return to PRESSED with cnt=0. Else count; at `DEBOUNCE_CYCLES`, go to RELEASED with no event.
  - `xHeld` = 1 in PRESSED and RELEASE_PEND.
- **Press event:** combinational, and true only on the edge that enters PRESSED from PRESS_PEND (or from RELEASED when `DEBOUNCE_CYCLES`=1). Release produces no event.
- **Tie filter:**
  - `leftButton` ← evL & ~evR.
  - `rightButton` ← evR & ~evL.
  - Both events on the same edge → both outputs 0 that cycle.
  - The `xHeld` outputs are unaffected by the tie filter.
- **No auto-repeat.** Holding indefinitely gives one pulse. The next pulse requires a debounced release followed by a debounced press.
- **Reset, including mid-operation:**
  - All FSMs go to RELEASED with cnt=0.
  - All outputs go to 0 on that edge.
  - Any pending count is discarded.
  - A key still held after Reset deasserts is treated as a fresh press and pulses after the normal latency.
- Unused or illegal FSM encodings recover to RELEASED on the next edge.

## Timing
- All outputs are registered. Reset value of `leftButton`, `rightButton`, `leftHeld` and `rightHeld` is 0.
- **Press latency:** counting the first rising edge that samples the pressed raw level as edge 1, `xButton` and `xHeld` rise on edge `DEBOUNCE_CYCLES`+2. With the default 4 this is edge 6.
- **Pulse width:** `xButton` is high for exactly one clk period.
- **Release latency:** `xHeld` falls on edge `DEBOUNCE_CYCLES`+2 after the first released sample.
- **Bounce rejection:** a raw level change lasting fewer than `DEBOUNCE_CYCLES` sampled cycles after synchronisation produces no output change.
- **Staggered presses:** L and R accepted one edge apart give two pulses on consecutive cycles, with no cancellation.

## Test plan
- **Clean press, default params:** Reset 2 cycles; keyL_raw 1→0 held 10 cycles. Required: leftButton=1 only after edge 6, 0 after edge 7; leftHeld=1 from edge 6; rightButton stays 0.
- **Bounce rejection:** keyR_raw low for 3 cycles then high, repeated 3 times. Required: rightButton and rightHeld stay 0 throughout.
- **Long hold and release:** keyL_raw low for 30 cycles, then high. Required: exactly one leftButton pulse; leftHeld falls 6 edges after release; no pulse on release.
- **Tie:** keyL_raw and keyR_raw go low on the same cycle. Required: leftButton=rightButton=0 on every cycle; leftHeld=rightHeld=1 at edge 6.
- **Stagger:** keyR_raw low one cycle after keyL_raw. Required: leftButton pulse at edge 6, rightButton pulse at edge 7, each one cycle wide.
- **Reset mid-debounce:**
  - Step 1: keyL_raw low; Reset=1 at edge 4 for 1 cycle. Required: no pulse, outputs 0.
  - Step 2: keep the key low after Reset deasserts. Required: leftButton pulses on edge 6 counted from the first post-reset edge.

Source files
------------

// File: rtl/tug_input_conditioner.sv
// Two-key synchronise/debounce/edge-detect with tie cancel; press pulse and held rise on edge DEBOUNCE_CYCLES+2.
// No backpressure: outputs are free-running registered pulses/levels.
module tug_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic Reset,
    input  logic keyL_raw,
    input  logic keyR_raw,
    output logic leftButton,
    output logic rightButton,
    output logic leftHeld,
    output logic rightHeld
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic REL_LVL = ACTIVE_LOW;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_PEND = 2'd3
    } state_t;

    // index 0 = left channel, index 1 = right channel
    logic [1:0] sync1, sync2, synced;
    state_t     state_q [2];
    state_t     state_d [2];
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    logic [1:0] ev;
    logic [1:0] held_d;

    always_ff @(posedge clk) begin
        if (Reset) begin
            sync1 <= {2{REL_LVL}};
            sync2 <= {2{REL_LVL}};
        end else begin
            sync1 <= {keyR_raw, keyL_raw};
            sync2 <= sync1;
        end
    end

    assign synced = ACTIVE_LOW ? ~sync2 : sync2;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (Reset) begin
                state_q[i] <= RELEASED;
                cnt_q[i]   <= '0;
            end else begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            ev[i]      = 1'b0;
            case (state_q[i])
                RELEASED: begin
                    if (synced[i]) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_d[i] = PRESSED;
                            cnt_d[i]   = '0;
                            ev[i]      = 1'b1;
                        end else begin
                            state_d[i] = PRESS_PEND;
                            cnt_d[i]   = CW'(1);
                        end
                    end
                end
                PRESS_PEND: begin
                    if (!synced[i]) begin
                        state_d[i] = RELEASED;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] + 1'b1 == CNT_MAX) begin
                        state_d[i] = PRESSED;
                        cnt_d[i]   = '0;
                        ev[i]      = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!synced[i]) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_d[i] = RELEASED;
                            cnt_d[i]   = '0;
                        end else begin
                            state_d[i] = RELEASE_PEND;
                            cnt_d[i]   = CW'(1);
                        end
                    end
                end
                RELEASE_PEND: begin
                    if (synced[i]) begin
                        state_d[i] = PRESSED;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] + 1'b1 == CNT_MAX) begin
                        state_d[i] = RELEASED;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                default: begin
                    state_d[i] = RELEASED;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            held_d[i] = (state_d[i] == PRESSED) || (state_d[i] == RELEASE_PEND);
        end
    end

    // Held levels are registered from next-state so they rise on the same edge as the pulse.
    always_ff @(posedge clk) begin
        if (Reset) begin
            leftButton  <= 1'b0;
            rightButton <= 1'b0;
            leftHeld    <= 1'b0;
            rightHeld   <= 1'b0;
        end else begin
            leftButton  <= ev[0] & ~ev[1];
            rightButton <= ev[1] & ~ev[0];
            leftHeld    <= held_d[0];
            rightHeld   <= held_d[1];
        end
    end
endmodule

// File: tb/tb_tug_input_conditioner.sv
// Scoreboard bench for tug_input_conditioner (default parameters): stimulus pushes per-edge expected
// {leftButton, rightButton, leftHeld, rightHeld}; a monitor pops and compares one entry per clock.
module tb_tug_input_conditioner;
    logic clk = 1'b0;
    logic Reset = 1'b1;
    logic keyL_raw = 1'b1;
    logic keyR_raw = 1'b1;
    logic leftButton, rightButton, leftHeld, rightHeld;

    int total = 0;
    int bad = 0;

    typedef struct {
        string      nm;
        int         idx;
        logic [3:0] e;
    } exp_t;

    exp_t sb[$];
    exp_t item;

    tug_input_conditioner dut (
        .clk        (clk),
        .Reset      (Reset),
        .keyL_raw   (keyL_raw),
        .keyR_raw   (keyR_raw),
        .leftButton (leftButton),
        .rightButton(rightButton),
        .leftHeld   (leftHeld),
        .rightHeld  (rightHeld)
    );

    always #5 clk = ~clk;

    // Drive inputs at the falling edge; the expectation describes outputs after the next rising edge.
    task automatic cyc(input string nm, input int idx, input logic kl, input logic kr,
                       input logic rst, input logic [3:0] e);
        @(negedge clk);
        keyL_raw = kl;
        keyR_raw = kr;
        Reset    = rst;
        sb.push_back('{nm, idx, e});
    endtask

    initial begin : monitor
        logic [3:0] act;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                item = sb.pop_front();
                act = {leftButton, rightButton, leftHeld, rightHeld};
                total++;
                if (act !== item.e) begin
                    bad++;
                    $display("FAIL %s edge %0d: got lb/rb/lh/rh=%b expected %b", item.nm, item.idx, act, item.e);
                end
            end
        end
    end

    initial begin : stim
        int waited;
        // reset and idle
        for (int j = 1; j <= 2; j++) cyc("reset", j, 1'b1, 1'b1, 1'b1, 4'b0000);
        for (int j = 1; j <= 3; j++) cyc("idle", j, 1'b1, 1'b1, 1'b0, 4'b0000);

        // clean left press, then release
        for (int j = 1; j <= 10; j++)
            cyc("clean", j, 1'b0, 1'b1, 1'b0, {j == 6, 1'b0, j >= 6, 1'b0});
        for (int j = 1; j <= 8; j++)
            cyc("clean_rel", j, 1'b1, 1'b1, 1'b0, {2'b00, j < 6, 1'b0});

        // right key bounces: 3 low, 3 high, three times
        for (int r = 0; r < 3; r++)
            for (int j = 0; j < 6; j++)
                cyc("bounce", r * 6 + j + 1, 1'b1, (j < 3) ? 1'b0 : 1'b1, 1'b0, 4'b0000);
        for (int j = 1; j <= 4; j++) cyc("bounce_idle", j, 1'b1, 1'b1, 1'b0, 4'b0000);

        // long hold: one pulse only, no pulse on release
        for (int j = 1; j <= 30; j++)
            cyc("long", j, 1'b0, 1'b1, 1'b0, {j == 6, 1'b0, j >= 6, 1'b0});
        for (int j = 1; j <= 10; j++)
            cyc("long_rel", j, 1'b1, 1'b1, 1'b0, {2'b00, j < 6, 1'b0});

        // tie: both pulses cancel, held levels unaffected
        for (int j = 1; j <= 10; j++)
            cyc("tie", j, 1'b0, 1'b0, 1'b0, {2'b00, j >= 6, j >= 6});
        for (int j = 1; j <= 8; j++)
            cyc("tie_rel", j, 1'b1, 1'b1, 1'b0, {2'b00, j < 6, j < 6});

        // stagger: right one cycle after left
        for (int j = 1; j <= 10; j++)
            cyc("stagger", j, 1'b0, (j >= 2) ? 1'b0 : 1'b1, 1'b0,
                {j == 6, j == 7, j >= 6, j >= 7});
        for (int j = 1; j <= 8; j++)
            cyc("stagger_rel", j, 1'b1, 1'b1, 1'b0, {2'b00, j < 6, j < 6});

        // right low for exactly DEBOUNCE_CYCLES samples: accepted, then released
        for (int j = 1; j <= 14; j++)
            cyc("min_press", j, 1'b1, (j <= 4) ? 1'b0 : 1'b1, 1'b0,
                {1'b0, j == 6, 1'b0, j >= 6 && j <= 9});

        // reset mid-debounce, key kept low afterwards
        for (int j = 1; j <= 3; j++) cyc("rst_mid", j, 1'b0, 1'b1, 1'b0, 4'b0000);
        cyc("rst_mid", 4, 1'b0, 1'b1, 1'b1, 4'b0000);
        for (int j = 1; j <= 10; j++)
            cyc("rst_after", j, 1'b0, 1'b1, 1'b0, {j == 6, 1'b0, j >= 6, 1'b0});
        for (int j = 1; j <= 8; j++)
            cyc("rst_rel", j, 1'b1, 1'b1, 1'b0, {2'b00, j < 6, 1'b0});

        waited = 0;
        while (sb.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        #2;
        if (sb.size() > 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
